load_store_unit: RTL

// Memory stage that sits directly downstream of the ALU. It takes the ALU result as the byte

---
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Memory stage behind the ALU. It turns a byte-addressed load/store into a doubleword-aligned
// valid/ready memory request, handles lane shifting and extension, and stalls the core until the access completes.
module load_store_unit #(
   parameter int MEM_AW = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [63:0]       req_addr,
   input  logic [63:0]       req_wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [63:0]       resp_rdata,
   output logic              misaligned,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [7:0]        mem_be,
   output logic [63:0]       mem_wdata,
   input  logic              mem_rvalid,
   input  logic [63:0]       mem_rdata
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_REQ    = 2'd1;
   localparam logic [1:0] ST_WAIT_R = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   logic [1:0]        state_r;
   logic [1:0]        state_nxt_s;
   logic [2:0]        off_r;
   logic [1:0]        size_r;
   logic              unsigned_r;
   logic              mem_valid_r;
   logic              mem_we_r;
   logic [MEM_AW-1:0] mem_addr_r;
   logic [7:0]        mem_be_r;
   logic [63:0]       mem_wdata_r;
   logic              resp_valid_r;
   logic [63:0]       resp_rdata_r;
   logic              misaligned_r;
   logic              misalign_s;
   logic              stall_s;
   logic              unused_addr_s;

   // An access must sit wholly inside one doubleword, i.e. be naturally aligned.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
      logic bad;
      case (size)
         2'b00:   bad = 1'b0;
         2'b01:   bad = (off[0] != 1'b0);
         2'b10:   bad = (off[1:0] != 2'b00);
         2'b11:   bad = (off != 3'b000);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

   function automatic logic [7:0] size_mask(input logic [1:0] size);
      logic [7:0] m;
      case (size)
         2'b00:   m = 8'h01;
         2'b01:   m = 8'h03;
         2'b10:   m = 8'h0F;
         2'b11:   m = 8'hFF;
         default: m = 8'h00;
      endcase
      return m;
   endfunction

   // Doubleword loads have nothing to extend, so the unsigned flag does not matter there.
   function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [1:0] size,
                                               input logic uns);
      logic [63:0] v;
      case (size)
         2'b00:   v = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
         2'b01:   v = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
         2'b10:   v = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
         2'b11:   v = raw;
         default: v = 64'd0;
      endcase
      return v;
   endfunction

   assign misalign_s    = is_misaligned(req_size, req_addr[2:0]);
   assign unused_addr_s = ^req_addr[63:MEM_AW+3];

   // Stall is combinational so the core freezes in the same cycle the request shows up.
   always_comb begin
      stall_s = 1'b0;
      if (rst) begin
         stall_s = 1'b0;
      end else begin
         stall_s = ((state_r == ST_IDLE) && req_valid) || (state_r == ST_REQ) ||
                   (state_r == ST_WAIT_R);
      end
   end

   // Next-state selection.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_valid) begin
               state_nxt_s = misalign_s ? ST_DONE : ST_REQ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (mem_ready) begin
               state_nxt_s = mem_we_r ? ST_DONE : ST_WAIT_R;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_WAIT_R: begin
            if (mem_rvalid) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_WAIT_R;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, memory-request and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         off_r        <= 3'd0;
         size_r       <= 2'd0;
         unsigned_r   <= 1'b0;
         mem_valid_r  <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= '0;
         mem_be_r     <= 8'h00;
         mem_wdata_r  <= 64'd0;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 64'd0;
         misaligned_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         resp_valid_r <= 1'b0;
         misaligned_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  off_r        <= req_addr[2:0];
                  size_r       <= req_size;
                  unsigned_r   <= req_unsigned;
                  resp_rdata_r <= 64'd0;
                  if (misalign_s) begin
                     resp_valid_r <= 1'b1;
                     misaligned_r <= 1'b1;
                  end else begin
                     mem_valid_r <= 1'b1;
                     mem_we_r    <= req_write;
                     mem_addr_r  <= req_addr[MEM_AW+2:3];
                     mem_be_r    <= size_mask(req_size) << req_addr[2:0];
                     mem_wdata_r <= req_wdata << {req_addr[2:0], 3'b000};
                  end
               end
            end
            ST_REQ: begin
               // Stores complete on acceptance; loads still wait for read data.
               if (mem_ready) begin
                  mem_valid_r  <= 1'b0;
                  resp_valid_r <= mem_we_r;
               end
            end
            ST_WAIT_R: begin
               if (mem_rvalid) begin
                  resp_rdata_r <= load_extend(mem_rdata >> {off_r, 3'b000}, size_r, unsigned_r);
                  resp_valid_r <= 1'b1;
               end
            end
            ST_DONE: begin
               resp_valid_r <= 1'b0;
            end
            default: begin
               resp_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign stall      = stall_s;
   assign resp_valid = resp_valid_r;
   assign resp_rdata = resp_rdata_r;
   assign misaligned = misaligned_r;
   assign mem_valid  = mem_valid_r;
   assign mem_we     = mem_we_r;
   assign mem_addr   = mem_addr_r;
   assign mem_be     = mem_be_r;
   assign mem_wdata  = mem_wdata_r;

endmodule
